tx_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares the single UART transmitter between `NUM_REQ` byte sources. It sits between the requesters (debounced-button timers, status reporters, etc.) and the transmitter's `i_Transmit`/`i_Data` inputs. The transmitter has no busy output, so this block holds each byte for a full frame time before issuing the next.

---
 rtl/tx_arbiter.sv | 154 +++++++++++++++
 tb/tb_tx_arbiter.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/tx_arbiter.sv
// rtl/tx_arbiter.sv - round-robin arbiter pacing byte sources onto one UART transmitter
//
// Ports:
//   i_Clk        clock, rising edge
//   i_Rst_n      asynchronous active-low reset
//   i_Req        per-requester byte request (level)
//   i_Data       requester k byte on i_Data[8k +: 8]
//   o_Grant      one-hot, one-cycle accept strobe
//   o_Transmit   transmitter start pulse, TX_PULSE clocks wide
//   o_Data       byte to transmitter, stable for the whole frame
//   o_Busy       high for exactly FRAME_CLKS clocks per frame

module tx_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int CLKS_PER_BIT = 868,
    parameter int FRAME_BITS   = 10,
    parameter int GAP_CLKS     = 0,
    parameter int TX_PULSE     = 1
) (
    input  logic                 i_Clk,
    input  logic                 i_Rst_n,
    input  logic [NUM_REQ-1:0]   i_Req,
    input  logic [8*NUM_REQ-1:0] i_Data,
    output logic [NUM_REQ-1:0]   o_Grant,
    output logic                 o_Transmit,
    output logic [7:0]           o_Data,
    output logic                 o_Busy
);

    localparam int FRAME_CLKS = CLKS_PER_BIT * FRAME_BITS + GAP_CLKS;
    localparam int CNT_W      = $clog2(FRAME_CLKS + 1);
    localparam int PTR_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    // Pulse counter holds TX_PULSE-1 down to 0.
    localparam int PUL_W      = (TX_PULSE > 1) ? $clog2(TX_PULSE) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t             state, state_n;
    logic [PTR_W-1:0]   ptr, ptr_n;
    logic [CNT_W-1:0]   cnt, cnt_n;
    logic [PUL_W-1:0]   pcnt, pcnt_n;
    logic [NUM_REQ-1:0] grant_n;
    logic               tx_n;
    logic [7:0]         data_n;
    logic               busy_n;

    logic               found;
    logic [PTR_W-1:0]   win;
    logic [7:0]         win_data;

    // Rotating priority search: first set request at or above ptr, wrapping.
    always_comb begin
        int j;
        j        = 0;
        found    = 1'b0;
        win      = '0;
        win_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            j = int'(ptr) + i;
            if (j >= NUM_REQ) begin
                j = j - NUM_REQ;
            end
            if (!found && i_Req[j]) begin
                found    = 1'b1;
                win      = PTR_W'(j);
                win_data = i_Data[8*j +: 8];
            end
        end
    end

    always_comb begin
        state_n = state;
        ptr_n   = ptr;
        cnt_n   = cnt;
        pcnt_n  = pcnt;
        grant_n = '0;
        tx_n    = o_Transmit;
        data_n  = o_Data;
        busy_n  = o_Busy;
        case (state)
            IDLE: begin
                tx_n   = 1'b0;
                busy_n = 1'b0;
                if (found) begin
                    grant_n = NUM_REQ'(1) << win;
                    data_n  = win_data;
                    tx_n    = 1'b1;
                    busy_n  = 1'b1;
                    cnt_n   = CNT_W'(FRAME_CLKS - 1);
                    pcnt_n  = PUL_W'(TX_PULSE - 1);
                    ptr_n   = (win == PTR_W'(NUM_REQ - 1)) ? '0 : win + PTR_W'(1);
                    state_n = SEND;
                end
            end
            SEND: begin
                // Frame end takes priority so TX_PULSE == FRAME_CLKS still closes cleanly.
                if (cnt == '0) begin
                    tx_n    = 1'b0;
                    busy_n  = 1'b0;
                    state_n = IDLE;
                end else begin
                    cnt_n = cnt - CNT_W'(1);
                    if (pcnt == '0) begin
                        tx_n    = 1'b0;
                        state_n = HOLD;
                    end else begin
                        pcnt_n = pcnt - PUL_W'(1);
                    end
                end
            end
            HOLD: begin
                tx_n = 1'b0;
                if (cnt == '0) begin
                    busy_n  = 1'b0;
                    state_n = IDLE;
                end else begin
                    cnt_n = cnt - CNT_W'(1);
                end
            end
            default: begin
                tx_n    = 1'b0;
                busy_n  = 1'b0;
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state      <= IDLE;
            ptr        <= '0;
            cnt        <= '0;
            pcnt       <= '0;
            o_Grant    <= '0;
            o_Transmit <= 1'b0;
            o_Data     <= '0;
            o_Busy     <= 1'b0;
        end else begin
            state      <= state_n;
            ptr        <= ptr_n;
            cnt        <= cnt_n;
            pcnt       <= pcnt_n;
            o_Grant    <= grant_n;
            o_Transmit <= tx_n;
            o_Data     <= data_n;
            o_Busy     <= busy_n;
        end
    end

endmodule

// File: tb/tb_tx_arbiter.sv
// tb/tb_tx_arbiter.sv - directed self-checking bench for tx_arbiter

module tb_tx_arbiter;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req;
    logic [31:0] dat;
    logic [3:0]  grant, grant3;
    logic        tx, tx3;
    logic [7:0]  odata, odata3;
    logic        busy, busy3;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    tx_arbiter #(.NUM_REQ(4), .CLKS_PER_BIT(4), .FRAME_BITS(10), .GAP_CLKS(2), .TX_PULSE(1)) dut (
        .i_Clk(clk), .i_Rst_n(rst_n), .i_Req(req), .i_Data(dat),
        .o_Grant(grant), .o_Transmit(tx), .o_Data(odata), .o_Busy(busy)
    );

    tx_arbiter #(.NUM_REQ(4), .CLKS_PER_BIT(4), .FRAME_BITS(10), .GAP_CLKS(2), .TX_PULSE(3)) dut3 (
        .i_Clk(clk), .i_Rst_n(rst_n), .i_Req(req), .i_Data(dat),
        .o_Grant(grant3), .o_Transmit(tx3), .o_Data(odata3), .o_Busy(busy3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  req;
        logic [31:0] data;
        logic [3:0]  exp_grant;
        logic [7:0]  exp_data;
    } vec_t;

    vec_t vecs[5];

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_grant(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (grant == 4'b0 && n < 100);
    endtask

    // Starts on the sample just after a grant edge; ends on the idle cycle after the frame.
    task automatic run_frame(output int busy_n, output int busy3_n, output int tx_n,
                             output int tx3_n, output int extra);
        busy_n = 0; busy3_n = 0; tx_n = 0; tx3_n = 0; extra = 0;
        for (int i = 0; i < 100 && (busy || busy3); i++) begin
            if (busy)  busy_n++;
            if (busy3) busy3_n++;
            if (tx)    tx_n++;
            if (tx3)   tx3_n++;
            if (i > 0 && grant != 4'b0) extra++;
            tick();
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 100 && busy; i++) tick();
    endtask

    initial begin
        int n, bn, b3n, tn, t3n, ex, early, last_cyc;
        int ord[6];

        vecs[0] = '{req: 4'b0100, data: 32'h0061_0000, exp_grant: 4'b0100, exp_data: 8'h61};
        vecs[1] = '{req: 4'b1111, data: 32'hA3A2_A1A0, exp_grant: 4'b1000, exp_data: 8'hA3};
        vecs[2] = '{req: 4'b0110, data: 32'hA3A2_A1A0, exp_grant: 4'b0010, exp_data: 8'hA1};
        vecs[3] = '{req: 4'b0011, data: 32'hA3A2_A1A0, exp_grant: 4'b0001, exp_data: 8'hA0};
        vecs[4] = '{req: 4'b1001, data: 32'hA3A2_A1A0, exp_grant: 4'b1000, exp_data: 8'hA3};
        ord = '{0, 1, 3, 0, 1, 3};

        // Reset values with all requests asserted
        rst_n = 1'b0;
        req   = 4'b1111;
        dat   = 32'hA3A2_A1A0;
        for (int i = 0; i < 3; i++) tick();
        check("rst_grant", {28'b0, grant}, 32'h0);
        check("rst_tx", {31'b0, tx}, 32'h0);
        check("rst_data", {24'b0, odata}, 32'h0);
        check("rst_busy", {31'b0, busy}, 32'h0);
        check("rst_busy3", {31'b0, busy3}, 32'h0);
        rst_n = 1'b1;
        wait_grant(n);
        check("first_latency", n, 1);
        check("first_grant", {28'b0, grant}, 32'h1);
        check("first_data", {24'b0, odata}, 32'hA0);
        req = 4'b0;
        run_frame(bn, b3n, tn, t3n, ex);
        check("first_busy_len", bn, 42);

        // Table: one request pattern per frame, ptr starts at 1
        for (int v = 0; v < 5; v++) begin
            req = vecs[v].req;
            dat = vecs[v].data;
            wait_grant(n);
            check($sformatf("v%0d_latency", v), n, 1);
            check($sformatf("v%0d_grant", v), {28'b0, grant}, {28'b0, vecs[v].exp_grant});
            check($sformatf("v%0d_data", v), {24'b0, odata}, {24'b0, vecs[v].exp_data});
            check($sformatf("v%0d_tx", v), {31'b0, tx}, 32'h1);
            check($sformatf("v%0d_busy", v), {31'b0, busy}, 32'h1);
            check($sformatf("v%0d_grant3", v), {28'b0, grant3}, {28'b0, vecs[v].exp_grant});
            check($sformatf("v%0d_data3", v), {24'b0, odata3}, {24'b0, vecs[v].exp_data});
            req = 4'b0;
            run_frame(bn, b3n, tn, t3n, ex);
            check($sformatf("v%0d_busy_len", v), bn, 42);
            check($sformatf("v%0d_busy3_len", v), b3n, 42);
            check($sformatf("v%0d_tx_len", v), tn, 1);
            check($sformatf("v%0d_tx3_len", v), t3n, 3);
            check($sformatf("v%0d_extra_grant", v), ex, 0);
            tick();
            check($sformatf("v%0d_no_more_grant", v), {28'b0, grant}, 32'h0);
            check($sformatf("v%0d_idle_busy", v), {31'b0, busy}, 32'h0);
        end

        // Round-robin with 1011 held, ptr starts at 0
        req = 4'b1011;
        dat = 32'hA3A2_A1A0;
        last_cyc = 0;
        for (int g = 0; g < 6; g++) begin
            wait_grant(n);
            check($sformatf("rr%0d_grant", g), {28'b0, grant}, 32'h1 << ord[g]);
            check($sformatf("rr%0d_data", g), {24'b0, odata}, 32'hA0 + ord[g]);
            if (g > 0) check($sformatf("rr%0d_spacing", g), cyc - last_cyc, 43);
            last_cyc = cyc;
        end
        req = 4'b0;
        drain();
        tick();

        // Late arrival during HOLD, ptr at 0
        req = 4'b0011;
        wait_grant(n);
        check("late_grant0", {28'b0, grant}, 32'h1);
        req = 4'b0010;
        early = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (grant != 4'b0) early++;
        end
        req = 4'b1010;
        for (int i = 0; i < 100 && busy; i++) begin
            tick();
            if (grant != 4'b0) early++;
        end
        check("late_no_early_grant", early, 0);
        wait_grant(n);
        check("late_grant1_latency", n, 1);
        check("late_grant1", {28'b0, grant}, 32'h2);
        check("late_data1", {24'b0, odata}, 32'hA1);
        req = 4'b1000;
        drain();
        wait_grant(n);
        check("late_grant3", {28'b0, grant}, 32'h8);
        check("late_data3", {24'b0, odata}, 32'hA3);
        req = 4'b0;
        drain();
        tick();

        // Asynchronous reset mid-frame
        req = 4'b0001;
        wait_grant(n);
        check("mid_grant", {28'b0, grant}, 32'h1);
        req = 4'b0;
        for (int i = 0; i < 19; i++) tick();
        check("mid_busy_before", {31'b0, busy}, 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy", {31'b0, busy}, 32'h0);
        check("mid_rst_tx", {31'b0, tx}, 32'h0);
        check("mid_rst_data", {24'b0, odata}, 32'h0);
        check("mid_rst_busy3", {31'b0, busy3}, 32'h0);
        req = 4'b0010;
        #2;
        rst_n = 1'b1;
        tick();
        check("post_rst_grant", {28'b0, grant}, 32'h2);
        check("post_rst_data", {24'b0, odata}, 32'hA1);
        req = 4'b0;
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
